note_recorder: RTL and testbench

Parametrised key front-end for the electronic piano: debounces NKEYS key inputs, priority-encodes them into a note code, and adds record/playback of note sequences on a fixed step tick. It sits between the board keys/switches and the display, 7-segment and buzzer consumers. It replaces the bare OR-encoder and the fixed auto-play path with one selectable source.

---
 rtl/elec_piano_pkg.sv | 36 +++
 rtl/key_debounce.sv | 46 ++++
 rtl/note_recorder.sv | 162 ++++++++++++++++
 tb/tb_note_recorder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/elec_piano_pkg.sv
// Shared definitions for the electronic piano key front-end and its consumers
// (lattice, buzzer, LED_num): mode codes, recorder state encoding, and the
// IDLE note code derivation.
package elec_piano_pkg;

  localparam logic [1:0] MODE_LIVE     = 2'b00;
  localparam logic [1:0] MODE_REC      = 2'b01;
  localparam logic [1:0] MODE_PLAY     = 2'b10;
  localparam logic [1:0] MODE_LIVE_ALT = 2'b11;

  typedef enum logic [1:0] {
    ST_LIVE = 2'd0,
    ST_REC  = 2'd1,
    ST_PLAY = 2'd2,
    ST_DONE = 2'd3
  } rec_state_t;

  // All-ones code of the given width means "no note".
  function automatic int idle_code(input int nw);
    return (1 << nw) - 1;
  endfunction

  // State a mode selection asks for; PLAY also covers DONE.
  function automatic rec_state_t mode_target(input logic [1:0] mode);
    rec_state_t st;
    st = ST_LIVE;
    case (mode)
      MODE_REC:                st = ST_REC;
      MODE_PLAY:               st = ST_PLAY;
      MODE_LIVE, MODE_LIVE_ALT: st = ST_LIVE;
      default:                 st = ST_LIVE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: two-flop synchroniser followed by a stability counter. The
// debounced level only follows the synchronised level once the two have
// differed for DEB_CYCLES consecutive cycles; any bounce restarts the count.
module key_debounce #(
  parameter int DEB_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key,
  output logic o_level
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Synchronise the raw key, then accept a new level after it has held long enough.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/note_recorder.sv
// Piano key front-end: debounced keys -> priority-encoded note, with a small
// record/playback buffer stepped by a fixed tick. Outputs are always
// registered; the buffer read address is the next read pointer so the
// one-cycle RAM latency is hidden behind the state transition.
module note_recorder
  import elec_piano_pkg::*;
#(
  parameter int NKEYS      = 7,
  parameter int NW         = $clog2(NKEYS + 1),
  parameter int DEPTH      = 64,
  parameter int TICK_DIV   = 15000000,
  parameter int DEB_CYCLES = 100000
) (
  input  logic                         sysclk,
  input  logic                         rst,
  input  logic [NKEYS-1:0]             keys,
  input  logic [1:0]                   tone,
  input  logic [1:0]                   mode,
  input  logic                         loop,
  output logic [NW-1:0]                note_out,
  output logic [1:0]                   tone_out,
  output logic [$clog2(DEPTH+1)-1:0]   rec_count,
  output logic                         rec_full,
  output logic                         play_done,
  output rec_state_t                   o_dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam int EW = NW + 2;
  localparam logic [NW-1:0] IDLE      = NW'(idle_code(NW));
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [NKEYS-1:0] w_deb;
  logic [NW-1:0]    w_code;
  logic             w_tick;
  logic             w_last;
  logic             w_enter;
  logic             w_wr_en;
  rec_state_t       w_target;
  rec_state_t       w_next;
  logic [AW-1:0]    w_rd_next;

  rec_state_t       r_state;
  logic [TW-1:0]    r_tick_cnt;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_rec_count;
  logic             r_rec_full;
  logic             r_play_done;
  logic [NW-1:0]    r_note;
  logic [1:0]       r_tone;
  logic [EW-1:0]    r_mem [DEPTH];
  logic [EW-1:0]    r_rd_data;

  for (genvar g = 0; g < NKEYS; g++) begin : g_deb
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (sysclk),
      .i_rst   (rst),
      .i_key   (keys[g]),
      .o_level (w_deb[g])
    );
  end

  // Priority encoder: the highest pressed key index wins.
  always_comb begin
    w_code = IDLE;
    for (int i = 0; i < NKEYS; i++) begin
      if (w_deb[i]) w_code = NW'(i);
    end
  end

  assign w_tick   = (r_tick_cnt == TICK_LAST);
  assign w_last   = (CW'(r_rd_ptr) == r_rec_count - CW'(1));
  assign w_target = mode_target(mode);
  assign w_enter  = (w_next != r_state);
  assign w_wr_en  = (r_state == ST_REC) && (w_next == ST_REC) && w_tick && !r_rec_full;

  // Next state: mode selection first, then end-of-playback inside PLAY.
  always_comb begin
    w_next = r_state;
    if (w_target == ST_PLAY) begin
      if (r_state == ST_LIVE || r_state == ST_REC) begin
        w_next = ST_PLAY;
      end else if (r_state == ST_PLAY) begin
        if (r_rec_count == '0) w_next = ST_DONE;
        else if (w_tick && w_last && !loop) w_next = ST_DONE;
      end
    end else begin
      w_next = w_target;
    end
  end

  // Next read pointer; also drives the RAM read address.
  always_comb begin
    w_rd_next = r_rd_ptr;
    if (w_enter && w_next == ST_PLAY) begin
      w_rd_next = '0;
    end else if (r_state == ST_PLAY && w_tick) begin
      w_rd_next = w_last ? '0 : r_rd_ptr + AW'(1);
    end
  end

  // State register, step tick, pointers and status flags.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_LIVE;
      r_tick_cnt  <= '0;
      r_rd_ptr    <= '0;
      r_rec_count <= '0;
      r_rec_full  <= 1'b0;
      r_play_done <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_ptr   <= w_rd_next;
      r_tick_cnt <= (w_enter || w_tick) ? '0 : r_tick_cnt + TW'(1);
      if (w_enter && w_next == ST_REC) begin
        r_rec_count <= '0;
        r_rec_full  <= 1'b0;
      end else if (w_wr_en) begin
        r_rec_count <= r_rec_count + CW'(1);
        r_rec_full  <= (r_rec_count == CW'(DEPTH - 1));
      end
      if (w_enter) r_play_done <= (w_next == ST_DONE);
    end
  end

  // Record buffer: write on REC ticks, registered read at the next pointer.
  always_ff @(posedge sysclk) begin
    if (w_wr_en) r_mem[r_rec_count[AW-1:0]] <= {tone, w_code};
    r_rd_data <= r_mem[w_rd_next];
  end

  // Output register: live input, playback data, or silence.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_note <= IDLE;
      r_tone <= 2'b00;
    end else if (w_next == ST_DONE || r_state == ST_DONE) begin
      r_note <= IDLE;
      r_tone <= 2'b00;
    end else if (r_state == ST_PLAY) begin
      if (r_rec_count == '0) begin
        r_note <= IDLE;
        r_tone <= 2'b00;
      end else begin
        {r_tone, r_note} <= r_rd_data;
      end
    end else begin
      r_note <= w_code;
      r_tone <= tone;
    end
  end

  assign note_out    = r_note;
  assign tone_out    = r_tone;
  assign rec_count   = r_rec_count;
  assign rec_full    = r_rec_full;
  assign play_done   = r_play_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with small parameters (DEPTH=4,
// TICK_DIV=10, DEB_CYCLES=3). Inputs change and outputs are sampled 1 ns
// after the rising edge; step(n) advances n rising edges.
module tb_note_recorder;
  import elec_piano_pkg::*;

  localparam int NKEYS = 7;
  localparam int NW    = 3;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int W     = NW + 2;
  localparam int IDLE  = 7;

  logic             sysclk;
  logic             rst;
  logic [NKEYS-1:0] keys;
  logic [1:0]       tone;
  logic [1:0]       mode;
  logic             loop;
  logic [NW-1:0]    note_out;
  logic [1:0]       tone_out;
  logic [CW-1:0]    rec_count;
  logic             rec_full;
  logic             play_done;
  rec_state_t       dbg_state;

  int n_checks;
  int n_pass;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] rec_exp [4];

  note_recorder #(
    .NKEYS(NKEYS), .DEPTH(DEPTH), .TICK_DIV(10), .DEB_CYCLES(3)
  ) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .keys        (keys),
    .tone        (tone),
    .mode        (mode),
    .loop        (loop),
    .note_out    (note_out),
    .tone_out    (tone_out),
    .rec_count   (rec_count),
    .rec_full    (rec_full),
    .play_done   (play_done),
    .o_dbg_state (dbg_state)
  );

  // Clock and reset
  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  task automatic step(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_note"}, int'(note_out), IDLE);
    check({tag, "_tone"}, int'(tone_out), 0);
    check({tag, "_count"}, int'(rec_count), 0);
    check({tag, "_full"}, int'(rec_full), 0);
    check({tag, "_done"}, int'(play_done), 0);
    check({tag, "_state"}, int'(dbg_state), int'(ST_LIVE));
  endtask

  // Compare the playback output against the next expected entry.
  task automatic check_play(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check(tag, int'({tone_out, note_out}), int'(e));
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst  = 1'b1;
    keys = '0;
    tone = 2'b00;
    mode = MODE_LIVE;
    loop = 1'b0;
    rec_exp[0] = 5'b01_001;
    rec_exp[1] = 5'b10_011;
    rec_exp[2] = 5'b11_111;
    rec_exp[3] = 5'b00_100;

    step(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    step(2);

    // keys[2] with bounce, final edge before E2
    keys = 7'b0000100; step(1);
    keys = 7'b0000000; step(1);
    keys = 7'b0000100;
    check("bounce_idle0", int'(note_out), IDLE);
    step(5);
    check("bounce_idle5", int'(note_out), IDLE);
    step(1);
    check("bounce_note2", int'(note_out), 2);
    keys = '0; step(8);
    check("release_idle", int'(note_out), IDLE);

    // keys[0] and keys[5] together, then drop keys[5]
    keys = 7'b0100001; step(6);
    check("prio_5", int'(note_out), 5);
    keys = 7'b0000001; step(5);
    check("prio_hold5", int'(note_out), 5);
    step(1);
    check("prio_0", int'(note_out), 0);
    keys = '0; step(8);

    // Record 1,3,IDLE,4 (+6 ignored) with tones 1,2,3,0
    keys = 7'b0000010; tone = 2'd1; step(8);
    check("live_note1", int'(note_out), 1);
    mode = MODE_REC; step(1);
    check("rec_state", int'(dbg_state), int'(ST_REC));
    check("rec_count0", int'(rec_count), 0);
    step(10);
    check("rec_count1", int'(rec_count), 1);
    check("rec_full1", int'(rec_full), 0);
    check("rec_track", int'({tone_out, note_out}), 9);
    keys = 7'b0001000; tone = 2'd2; step(10);
    check("rec_count2", int'(rec_count), 2);
    keys = 7'b0000000; tone = 2'd3; step(10);
    check("rec_count3", int'(rec_count), 3);
    check("rec_full3", int'(rec_full), 0);
    keys = 7'b0010000; tone = 2'd0; step(10);
    check("rec_count4", int'(rec_count), 4);
    check("rec_full4", int'(rec_full), 1);
    keys = 7'b1000000; tone = 2'd1; step(10);
    check("rec_count5", int'(rec_count), 4);
    check("rec_full5", int'(rec_full), 1);
    check("rec_stay", int'(dbg_state), int'(ST_REC));

    // Playback, loop=0
    for (int i = 0; i < 4; i++) exp_q.push_back(rec_exp[i]);
    mode = MODE_PLAY; loop = 1'b0; step(2);
    for (int i = 0; i < 4; i++) begin
      check_play($sformatf("play%0d", i));
      check($sformatf("play%0d_done", i), int'(play_done), 0);
      if (i < 3) step(10);
    end
    step(8);
    check("play_hold_last", int'(note_out), 4);
    step(1);
    check("done_note", int'(note_out), IDLE);
    check("done_tone", int'(tone_out), 0);
    check("done_flag", int'(play_done), 1);
    check("done_state", int'(dbg_state), int'(ST_DONE));
    step(3);
    check("done_held", int'(play_done), 1);

    // Playback, loop=1: sequence repeats
    mode = MODE_LIVE; loop = 1'b1; step(2);
    for (int i = 0; i < 6; i++) exp_q.push_back(rec_exp[i % 4]);
    mode = MODE_PLAY; step(2);
    for (int i = 0; i < 6; i++) begin
      check_play($sformatf("loop%0d", i));
      if (i < 5) step(10);
    end
    check("loop_done", int'(play_done), 0);

    // Reset mid-PLAY
    step(3);
    rst = 1'b1; #1;
    check_reset_outputs("rst_play");
    mode = MODE_LIVE; step(1);
    rst = 1'b0; step(1);
    check("post_rst_state", int'(dbg_state), int'(ST_LIVE));

    // Playback of an empty buffer
    mode = MODE_PLAY; step(1);
    check("empty_play_state", int'(dbg_state), int'(ST_PLAY));
    check("empty_done0", int'(play_done), 0);
    step(1);
    check("empty_done1", int'(play_done), 1);
    check("empty_note", int'(note_out), IDLE);
    check("empty_state", int'(dbg_state), int'(ST_DONE));

    // Reset mid-REC
    mode = MODE_REC; step(11);
    check("rec2_count1", int'(rec_count), 1);
    step(3);
    rst = 1'b1; #1;
    check_reset_outputs("rst_rec");
    mode = MODE_LIVE; step(1);
    rst = 1'b0; step(2);
    check("post_rst2_state", int'(dbg_state), int'(ST_LIVE));
    check("post_rst2_count", int'(rec_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
